// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel-source / bit-mux / strip-pin signal bundle for the WS2812 frame controller.
// The controller uses the slave modport; the source side (pixel source plus mux) uses master.
interface ws2812_frame_ctrl_if #(
    parameter int NUM_LEDS = 16
);
    localparam int LIDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic              start;
    logic [23:0]       color_data;
    logic              color_valid;
    logic              color_ready;
    logic [LIDX_W-1:0] led_idx;
    logic [23:0]       color_q;
    logic [4:0]        controlcolor;
    logic              sendbit;
    logic              dout;
    logic              busy;
    logic              done;

    modport master (
        output start, color_data, color_valid, sendbit,
        input  color_ready, led_idx, color_q, controlcolor, dout, busy, done
    );

    modport slave (
        input  start, color_data, color_valid, sendbit,
        output color_ready, led_idx, color_q, controlcolor, dout, busy, done
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: fetches one GRB word per LED, walks its 24 bits through the
// external bit mux and drives the NRZ waveform, followed by the end-of-frame latch gap.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS = 16,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63,
    parameter int TRES_CYC = 2500
) (
    input  logic                   clk,
    input  logic                   rst,
    ws2812_frame_ctrl_if.slave     bus
);
    localparam int LIDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CNT_MAX = (TBIT_CYC > TRES_CYC) ? TBIT_CYC : TRES_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]  T0H_END  = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0]  T1H_END  = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0]  TBIT_END = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0]  TRES_END = CNT_W'(TRES_CYC - 1);
    localparam logic [LIDX_W-1:0] LAST_LED = LIDX_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] th_end;

    // color_q and controlcolor are held for the whole bit, so the mux output is stable in HIGH
    always_comb th_end = bus.sendbit ? T1H_END : T0H_END;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.dout         <= 1'b0;
            bus.color_ready  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.controlcolor <= '0;
            bus.color_q      <= '0;
            bus.led_idx      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= LOAD;
                        bus.led_idx     <= '0;
                        bus.busy        <= 1'b1;
                        bus.color_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.color_valid && bus.color_ready) begin
                        bus.color_q      <= bus.color_data;
                        bus.controlcolor <= '0;
                        bus.color_ready  <= 1'b0;
                        bus.dout         <= 1'b1;
                        cnt              <= '0;
                        state            <= HIGH;
                    end
                end
                HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == th_end) begin
                        bus.dout <= 1'b0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == TBIT_END) begin
                        cnt <= '0;
                        if (bus.controlcolor != 5'd23) begin
                            bus.controlcolor <= bus.controlcolor + 5'd1;
                            bus.dout         <= 1'b1;
                            state            <= HIGH;
                        end else if (bus.led_idx != LAST_LED) begin
                            bus.led_idx     <= bus.led_idx + 1'b1;
                            bus.color_ready <= 1'b1;
                            state           <= LOAD;
                        end else begin
                            state <= LATCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == TRES_END) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl with a 2-LED strip; the bench models the 24:1 bit mux
// and the pixel source, and checks pulse widths, bit periods, latch gap and handshakes.
module tb_ws2812_frame_ctrl;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [23:0] words [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_frame_ctrl_if #(.NUM_LEDS(N)) bus ();

    ws2812_frame_ctrl #(.NUM_LEDS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.color_data = words[bus.led_idx];
    assign bus.sendbit    = bus.color_q[23 - int'(bus.controlcolor)];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rise(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.dout === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Measures every bit of a frame (valid held), then the latch gap and the done pulse.
    task automatic run_frame(input int pulse_bit);
        int          prev_rise;
        int          hi;
        int          n;
        bit          ok;
        bit          saw_high;
        logic [23:0] w;
        prev_rise = 0;
        for (int b = 0; b < 24 * N; b++) begin
            wait_rise(400, ok);
            if (!ok) begin
                chk($sformatf("rise_timeout_bit%0d", b), 32'd0, 32'd1);
                return;
            end
            w = words[b / 24];
            chk($sformatf("controlcolor_bit%0d", b), 32'(bus.controlcolor), 32'(b % 24));
            chk($sformatf("led_idx_bit%0d", b), 32'(bus.led_idx), 32'(b / 24));
            chk($sformatf("color_q_bit%0d", b), 32'(bus.color_q), 32'(w));
            if (b > 0)
                chk($sformatf("bit_period_bit%0d", b), 32'(cyc - prev_rise), (b == 24) ? 32'd64 : 32'd63);
            prev_rise = cyc;
            hi = 0;
            if (b == pulse_bit) bus.start = 1'b1;
            while (bus.dout === 1'b1 && hi < 100) begin
                hi++;
                @(negedge clk);
                bus.start = 1'b0;
            end
            chk($sformatf("high_width_bit%0d", b), 32'(hi), w[23 - (b % 24)] ? 32'd40 : 32'd20);
        end
        n = 0;
        saw_high = 1'b0;
        while (bus.done !== 1'b1 && n < 3000) begin
            if (bus.dout !== 1'b0) saw_high = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("latch_dout_low", 32'(saw_high), 32'd0);
        chk("done_delay", 32'(cyc - prev_rise), 32'(63 + 2500));
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit stall_bad;
        bit ok;
        bus.start       = 1'b0;
        bus.color_valid = 1'b0;
        words[0]        = 24'h0;
        words[1]        = 24'h0;
        repeat (3) @(negedge clk);

        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_color_ready", 32'(bus.color_ready), 32'd0);
        chk("rst_controlcolor", 32'(bus.controlcolor), 32'd0);
        chk("rst_color_q", 32'(bus.color_q), 32'd0);
        chk("rst_led_idx", 32'(bus.led_idx), 32'd0);

        rst = 1'b0;
        words[0] = 24'hFF0000;
        words[1] = 24'h00FF00;
        bus.color_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_color_ready", 32'(bus.color_ready), 32'd0);
        chk("idle_valid_ignored", 32'(bus.color_q), 32'd0);

        // Frame 1: valid held, stray start mid-frame
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("load_color_ready", 32'(bus.color_ready), 32'd1);
        run_frame(10);

        // Frame 2: start in the done cycle
        words[0] = 24'hA5C33C;
        words[1] = 24'h0F0F0F;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_done_low", 32'(bus.done), 32'd0);
        run_frame(-1);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Frame 3: source stalls 100 cycles in LOAD
        bus.color_valid = 1'b0;
        words[0] = 24'h123456;
        words[1] = 24'hFEDCBA;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        stall_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.color_ready !== 1'b1 || bus.dout !== 1'b0 || bus.color_q !== 24'h0F0F0F)
                stall_bad = 1'b1;
            @(negedge clk);
        end
        chk("stall_ready_dout", 32'(stall_bad), 32'd0);
        bus.color_valid = 1'b1;
        run_frame(-1);

        // Reset during HIGH of bit 5, then a full frame
        words[0] = 24'h5A5A5A;
        words[1] = 24'h3C3CC3;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.dout === 1'b1 && bus.controlcolor === 5'd5) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_bit5", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_dout", 32'(bus.dout), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_controlcolor", 32'(bus.controlcolor), 32'd0);
        chk("midrst_color_q", 32'(bus.color_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_frame(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
